// File: rtl/audio_system_debug_ocimem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_system_debug_ocimem_pkg
//  Description : Shared types and constants for the debug on-chip memory:
//                FSM states, JTAG command encoding, RAM geometry and the
//                bit positions of the fields carried on jdo.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_system_debug_ocimem_pkg;

    // RAM geometry
    localparam int RAM_DEPTH = 256;
    localparam int RAM_AW    = 8;
    localparam int DATA_W    = 32;

    // jdo field positions
    localparam int JDO_W            = 38;
    localparam int JDO_SET_ADDR_BIT = 17;
    localparam int JDO_ADDR_LO      = 26;
    localparam int JDO_ADDR_HI      = 33;
    localparam int JDO_READ_BIT     = 34;
    localparam int JDO_WDATA_LO     = 3;
    localparam int JDO_WDATA_HI     = 34;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AV_RD   = 3'd1,
        ST_AV_DONE = 3'd2,
        ST_J_RD    = 3'd3,
        ST_J_CAP   = 3'd4,
        ST_J_WR    = 3'd5
    } state_e;

    // Type of the JTAG command held in the pending slot
    typedef enum logic {
        JCMD_RD = 1'b0,
        JCMD_WR = 1'b1
    } jcmd_e;

    // One-entry JTAG pending slot
    typedef struct packed {
        logic                valid;
        jcmd_e               cmd;
        logic [RAM_AW-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } jslot_t;

    // True while the controller is servicing a JTAG command
    function automatic logic is_jtag_state(input state_e s);
        return (s == ST_J_RD) || (s == ST_J_CAP) || (s == ST_J_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_system_debug_ocimem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : audio_system_debug_ocimem_ram
//  Description : 256 x 32 single-port RAM with per-byte write enables and a
//                registered read port (one cycle latency). No reset, so it
//                maps onto a block RAM. Read-during-write returns old data.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_system_debug_ocimem_ram
    import audio_system_debug_ocimem_pkg::*;
(
    input  logic                clk,
    input  logic [RAM_AW-1:0]   addr_i,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-masked write and registered read share one port address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/audio_system_debug_ocimem.sv
`default_nettype none
// ============================================================================
//  Module      : audio_system_debug_ocimem
//  Description : Debug on-chip memory shared between an Avalon slave port and
//                JTAG debug commands. JTAG commands are parked in a one-entry
//                slot and win arbitration in IDLE; Avalon transfers are never
//                pre-empted once started.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_system_debug_ocimem
    import audio_system_debug_ocimem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [JDO_W-1:0]     jdo,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_no_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    input  logic [8:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [DATA_W-1:0]    writedata,
    input  logic [3:0]           byteenable,
    input  logic                 debugaccess,
    output logic [DATA_W-1:0]    readdata,
    output logic                 waitrequest,
    output logic [DATA_W-1:0]    MonDReg,
    output logic                 jtag_busy,
    output logic                 jtag_overrun
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    jslot_t              slot_q, slot_d;
    logic [RAM_AW-1:0]   mona_q, mona_d;
    logic [DATA_W-1:0]   mond_q, mond_d;
    logic [DATA_W-1:0]   readdata_q, readdata_d;
    logic                overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_addr;
    logic [3:0]          w_ram_be;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic                w_slot_clear;
    logic                w_jwr_commit;
    logic                w_any_take;
    logic [RAM_AW-1:0]   w_take_a_addr;
    logic [RAM_AW-1:0]   w_mona_inc;
    logic                w_unused_jdo;

    // Bits of jdo that carry nothing for this block
    assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_READ_BIT+1], jdo[JDO_WDATA_LO-1:0]};

    assign w_any_take    = take_action_ocimem_a | take_no_action_ocimem_a |
                           take_action_ocimem_b;
    assign w_take_a_addr = jdo[JDO_SET_ADDR_BIT] ? jdo[JDO_ADDR_HI:JDO_ADDR_LO]
                                                 : mona_q;
    assign w_mona_inc    = mona_q + 8'd1;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    audio_system_debug_ocimem_ram u_ram (
        .clk     (clk),
        .addr_i  (w_ram_addr),
        .we_i    (w_ram_we),
        .be_i    (w_ram_be),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, RAM port steering and data-capture selection.
    always_comb begin
        state_d      = state_q;
        w_ram_addr   = address[RAM_AW-1:0];
        w_ram_we     = 1'b0;
        w_ram_be     = byteenable;
        w_ram_wdata  = writedata;
        readdata_d   = readdata_q;
        mond_d       = mond_q;
        w_slot_clear = 1'b0;
        w_jwr_commit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (slot_q.valid) begin
                    // Pending JTAG command owns the RAM port this cycle
                    w_ram_addr = slot_q.addr;
                    if (slot_q.cmd == JCMD_WR) begin
                        w_ram_we     = 1'b1;
                        w_ram_be     = 4'hF;
                        w_ram_wdata  = slot_q.data;
                        w_slot_clear = 1'b1;
                        w_jwr_commit = 1'b1;
                        state_d      = ST_J_WR;
                    end else begin
                        state_d = ST_J_RD;
                    end
                end else if (read) begin
                    state_d = ST_AV_RD;
                end else if (write) begin
                    // Writes always complete; only debug-mode RAM writes stick
                    w_ram_we = debugaccess & ~address[8];
                    state_d  = ST_AV_DONE;
                end
            end
            ST_AV_RD: begin
                readdata_d = address[8] ? {{(DATA_W-RAM_AW){1'b0}}, mona_q}
                                        : w_ram_rdata;
                state_d    = ST_AV_DONE;
            end
            ST_AV_DONE: begin
                state_d = ST_IDLE;
            end
            ST_J_RD: begin
                mond_d       = w_ram_rdata;
                w_slot_clear = 1'b1;
                state_d      = ST_J_CAP;
            end
            ST_J_CAP: begin
                state_d = ST_IDLE;
            end
            ST_J_WR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // JTAG slot, MonAReg and overrun next-state: accept a pulse only into an
    // empty slot. Service clears only happen with the slot full, so they
    // never collide with an accepted pulse.
    always_comb begin
        slot_d    = slot_q;
        mona_d    = mona_q;
        overrun_d = overrun_q;

        if (w_slot_clear) begin
            slot_d.valid = 1'b0;
        end
        if (w_jwr_commit) begin
            mona_d = slot_q.addr + 8'd1;
        end

        if (w_any_take) begin
            if (slot_q.valid) begin
                overrun_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                mona_d = w_take_a_addr;
                if (jdo[JDO_READ_BIT]) begin
                    slot_d.valid = 1'b1;
                    slot_d.cmd   = JCMD_RD;
                    slot_d.addr  = w_take_a_addr;
                    slot_d.data  = '0;
                end
            end else if (take_no_action_ocimem_a) begin
                mona_d       = w_mona_inc;
                slot_d.valid = 1'b1;
                slot_d.cmd   = JCMD_RD;
                slot_d.addr  = w_mona_inc;
                slot_d.data  = '0;
            end else begin
                slot_d.valid = 1'b1;
                slot_d.cmd   = JCMD_WR;
                slot_d.addr  = mona_q;
                slot_d.data  = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
            end
        end
    end

    // Architectural registers; RAM contents deliberately survive reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= '0;
            mona_q     <= '0;
            mond_q     <= '0;
            readdata_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            mona_q     <= mona_d;
            mond_q     <= mond_d;
            readdata_q <= readdata_d;
            overrun_q  <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign readdata     = readdata_q;
    assign waitrequest  = (state_q != ST_AV_DONE);
    assign MonDReg      = mond_q;
    assign jtag_busy    = slot_q.valid | is_jtag_state(state_q);
    assign jtag_overrun = overrun_q;

endmodule
`default_nettype wire
